// File: rtl/and_gate.sv
// Bitwise AND with a zero-latency combinational result plus a clocked side:
// registered result, per-bit rising-edge pulse, all-high flag and saturating all-high cycle count.
module and_gate #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] y_q,
  output logic [WIDTH-1:0] y_rise,
  output logic             all_hi,
  output logic [CNT_W-1:0] hi_cnt
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [WIDTH-1:0] res_d, res_q;
  logic [WIDTH-1:0] rise_d, rise_q;
  logic             all_hi_d, all_hi_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;

  // Structural path: must not depend on any clocked input so chained instances settle at once.
  assign y = a & b;

  // Next-state: hold when disabled, except the rise pulse which always drops.
  always_comb begin
    res_d    = res_q;
    rise_d   = '0;
    all_hi_d = all_hi_q;
    cnt_d    = cnt_q;
    if (en) begin
      res_d    = a & b;
      rise_d   = (a & b) & ~res_q;
      all_hi_d = &(a & b);
      if ((&(a & b)) && (cnt_q != CntMax)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_q    <= '0;
      rise_q   <= '0;
      all_hi_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      res_q    <= res_d;
      rise_q   <= rise_d;
      all_hi_q <= all_hi_d;
      cnt_q    <= cnt_d;
    end
  end

  assign y_q    = res_q;
  assign y_rise = rise_q;
  assign all_hi = all_hi_q;
  assign hi_cnt = cnt_q;

endmodule

// File: tb/tb_and_gate.sv
// Directed-vector bench for and_gate: truth table, two-instance chain, registered stage,
// enable hold, counter saturation and reset priority.
module tb_and_gate;

  int n_vec = 0;
  int n_err = 0;

  // Idle clocked side for the purely combinational instances.
  logic       clk_off = 1'b0;
  logic       rst_off = 1'b0;
  logic       en_off  = 1'b0;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // 1-bit truth-table instance
  logic       ta, tb, ty;
  logic       t_yq, t_rise, t_ah;
  logic [7:0] t_cnt;
  and_gate u_tt (.a(ta), .b(tb), .y(ty), .clk(clk_off), .rst(rst_off), .en(en_off),
                 .y_q(t_yq), .y_rise(t_rise), .all_hi(t_ah), .hi_cnt(t_cnt));

  // Two chained 1-bit instances: (ca & cb) & cc
  logic       ca, cb, cc, cm, cy;
  logic       c0_yq, c0_rise, c0_ah, c1_yq, c1_rise, c1_ah;
  logic [7:0] c0_cnt, c1_cnt;
  and_gate u_ch0 (.a(ca), .b(cb), .y(cm), .clk(clk_off), .rst(rst_off), .en(en_off),
                  .y_q(c0_yq), .y_rise(c0_rise), .all_hi(c0_ah), .hi_cnt(c0_cnt));
  and_gate u_ch1 (.a(cm), .b(cc), .y(cy), .clk(clk_off), .rst(rst_off), .en(en_off),
                  .y_q(c1_yq), .y_rise(c1_rise), .all_hi(c1_ah), .hi_cnt(c1_cnt));

  // WIDTH=4 instance for the registered stage
  logic [3:0] wa, wb, wy, wyq, wrise;
  logic       wrst, wen, wah;
  logic [7:0] wcnt;
  and_gate #(.WIDTH(4)) u_w4 (.a(wa), .b(wb), .y(wy), .clk(clk), .rst(wrst), .en(wen),
                              .y_q(wyq), .y_rise(wrise), .all_hi(wah), .hi_cnt(wcnt));

  // WIDTH=2, CNT_W=3 instance for saturation
  logic [1:0] sa, sb, sy, syq, srise;
  logic       srst, sen, sah;
  logic [2:0] scnt;
  and_gate #(.WIDTH(2), .CNT_W(3)) u_c3 (.a(sa), .b(sb), .y(sy), .clk(clk), .rst(srst), .en(sen),
                                        .y_q(syq), .y_rise(srise), .all_hi(sah), .hi_cnt(scnt));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_truth_table();
    logic [1:0] ab;
    logic       exp_y;
    for (int i = 0; i < 4; i++) begin
      ab = 2'(i);
      ta = ab[1];
      tb = ab[0];
      exp_y = (i == 3) ? 1'b1 : 1'b0;
      #1;
      n_vec++;
      if (ty !== exp_y) begin
        n_err++;
        $display("FAIL truth_table a=%b b=%b: y=%b expected %b", ta, tb, ty, exp_y);
      end
    end
  endtask

  task automatic test_chain();
    logic [2:0] v;
    logic       exp_y;
    for (int i = 0; i < 8; i++) begin
      v  = 3'(7 - i);
      ca = v[2];
      cb = v[1];
      cc = v[0];
      exp_y = (v == 3'b111) ? 1'b1 : 1'b0;
      #1;
      n_vec++;
      if (cy !== exp_y) begin
        n_err++;
        $display("FAIL chain abc=%b: y=%b expected %b", v, cy, exp_y);
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    wrst = 1'b1; wen = 1'b1; wa = 4'hF; wb = 4'hF;
    step();
    step();
    n_vec++;
    if ({wyq, wrise, wah, wcnt} !== 17'd0) begin
      n_err++;
      $display("FAIL reset: y_q=%h y_rise=%h all_hi=%b hi_cnt=%0d expected all 0", wyq, wrise, wah, wcnt);
    end
    n_vec++;
    if (wy !== 4'hF) begin
      n_err++;
      $display("FAIL reset_y_tracks: y=%h expected f", wy);
    end
  endtask

  task automatic test_registered();
    @(negedge clk);
    wrst = 1'b0; wen = 1'b1; wa = 4'b1011; wb = 4'b1110;
    #1;
    n_vec++;
    if (wy !== 4'b1010) begin
      n_err++;
      $display("FAIL comb_w4: y=%b expected 1010", wy);
    end
    step();
    n_vec++;
    if ({wyq, wrise, wah, wcnt} !== {4'b1010, 4'b1010, 1'b0, 8'd0}) begin
      n_err++;
      $display("FAIL first_edge: y_q=%b y_rise=%b all_hi=%b hi_cnt=%0d expected 1010 1010 0 0",
               wyq, wrise, wah, wcnt);
    end
    step();
    n_vec++;
    if ({wyq, wrise} !== {4'b1010, 4'b0000}) begin
      n_err++;
      $display("FAIL back_to_back: y_q=%b y_rise=%b expected 1010 0000", wyq, wrise);
    end
  endtask

  task automatic test_enable_hold();
    @(negedge clk);
    wen = 1'b0; wa = 4'hF; wb = 4'hF;
    #1;
    n_vec++;
    if (wy !== 4'hF) begin
      n_err++;
      $display("FAIL hold_comb: y=%h expected f", wy);
    end
    step();
    n_vec++;
    if ({wyq, wrise, wah, wcnt} !== {4'b1010, 4'b0000, 1'b0, 8'd0}) begin
      n_err++;
      $display("FAIL hold: y_q=%b y_rise=%b all_hi=%b hi_cnt=%0d expected 1010 0000 0 0",
               wyq, wrise, wah, wcnt);
    end
    // Re-enable: only the bits that were low in y_q should pulse.
    @(negedge clk);
    wen = 1'b1;
    step();
    n_vec++;
    if ({wyq, wrise, wah, wcnt} !== {4'hF, 4'b0101, 1'b1, 8'd1}) begin
      n_err++;
      $display("FAIL reenable: y_q=%b y_rise=%b all_hi=%b hi_cnt=%0d expected 1111 0101 1 1",
               wyq, wrise, wah, wcnt);
    end
    // Disabled cycle with all-high inputs must not count.
    @(negedge clk);
    wen = 1'b0;
    step();
    n_vec++;
    if ({wrise, wah, wcnt} !== {4'b0000, 1'b1, 8'd1}) begin
      n_err++;
      $display("FAIL hold_cnt: y_rise=%b all_hi=%b hi_cnt=%0d expected 0000 1 1", wrise, wah, wcnt);
    end
  endtask

  task automatic test_saturate();
    logic [2:0] exp_cnt;
    @(negedge clk);
    srst = 1'b1; sen = 1'b0; sa = 2'b11; sb = 2'b11;
    step();
    @(negedge clk);
    srst = 1'b0; sen = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      exp_cnt = (i > 7) ? 3'd7 : 3'(i);
      n_vec++;
      if (scnt !== exp_cnt) begin
        n_err++;
        $display("FAIL saturate cycle %0d: hi_cnt=%0d expected %0d", i, scnt, exp_cnt);
      end
    end
    // Partial match: counter holds and all_hi drops.
    @(negedge clk);
    sb = 2'b01;
    step();
    n_vec++;
    if ({syq, sah, scnt} !== {2'b01, 1'b0, 3'd7}) begin
      n_err++;
      $display("FAIL partial: y_q=%b all_hi=%b hi_cnt=%0d expected 01 0 7", syq, sah, scnt);
    end
  endtask

  task automatic test_reset_priority();
    @(negedge clk);
    sb = 2'b11; srst = 1'b1; sen = 1'b1;
    step();
    n_vec++;
    if ({syq, srise, sah, scnt} !== 8'd0) begin
      n_err++;
      $display("FAIL reset_over_en: y_q=%b y_rise=%b all_hi=%b hi_cnt=%0d expected all 0",
               syq, srise, sah, scnt);
    end
    @(negedge clk);
    srst = 1'b0;
    step();
    n_vec++;
    if ({syq, srise, sah, scnt} !== {2'b11, 2'b11, 1'b1, 3'd1}) begin
      n_err++;
      $display("FAIL post_reset: y_q=%b y_rise=%b all_hi=%b hi_cnt=%0d expected 11 11 1 1",
               syq, srise, sah, scnt);
    end
  endtask

  initial begin
    ta = 1'b0; tb = 1'b0;
    ca = 1'b0; cb = 1'b0; cc = 1'b0;
    wa = '0; wb = '0; wrst = 1'b1; wen = 1'b0;
    sa = '0; sb = '0; srst = 1'b1; sen = 1'b0;
    test_truth_table();
    test_chain();
    test_reset();
    test_registered();
    test_enable_hold();
    test_saturate();
    test_reset_priority();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/and_gate.md
# and_gate

Two-input bitwise AND primitive with a registered copy of the result and simple activity monitoring. Structural logic uses the zero-latency combinational output, and 1-bit instances are chained to build wider AND terms, so `y` of one instance feeds `a` of the next. The clocked side provides a registered output, a per-bit rising-edge pulse, and a saturating count of cycles in which all result bits are high. Timing paths, status flags and debug logic use the clocked side.

## Interface
Parameters:
- `WIDTH`, default 1: bit width of operands and result.
- `CNT_W`, default 8: width of the all-high cycle counter.

Ports (clock and reset first):
- `clk`  input  1: single clock; all state updates on its rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `a`  input  WIDTH: operand A.
- `b`  input  WIDTH: operand B.
- `y`  output  WIDTH: combinational `a & b`.
- `en`  input  1: update enable for the registered stage and the counter.
- `y_q`  output  WIDTH: registered `a & b`.
- `y_rise`  output  WIDTH: one-cycle pulse per bit when `y_q` goes 0→1.
- `all_hi`  output  1: registered reduction AND of `y_q`.
- `hi_cnt`  output  CNT_W: saturating count of enabled cycles with `&(a & b)` = 1.

Declaration order is `a`, `b`, `y`, `clk`, `rst`, `en`, `y_q`, `y_rise`, `all_hi`, `hi_cnt`. Positional three-port instantiations `(a, b, y)` stay valid. In such instances `y` must work with every clocked port unconnected.

## Operation
- `y = a & b`, bitwise, purely combinational. It has no dependence on `clk`, `rst` or `en`, and X/Z on inputs follows standard Verilog `&` semantics.
- Registered stage, on rising `clk`:
  - `rst`=1: `y_q`←0, `y_rise`←0, `all_hi`←0, `hi_cnt`←0. `rst` overrides `en`.
  - `rst`=0, `en`=1: `y_q`←`a & b` and `all_hi`←`&(a & b)`. `y_rise`←`(a & b) & ~y_q`, using the old `y_q`. `hi_cnt`←`hi_cnt`+1 when `&(a & b)`=1 and `hi_cnt` ≠ 2^CNT_W−1, otherwise it holds.
  - `rst`=0, `en`=0: `y_q`, `all_hi` and `hi_cnt` hold. `y_rise`←0, so a pulse never stretches.
- Saturation: `hi_cnt` stops at all-ones and never wraps. Only `rst` clears it.
- `WIDTH`=1: `all_hi` equals `y_q`.

## Timing
- `y`: 0 cycles, settles in the same delta as its inputs. Chained instances settle within one time step, with no added delay.
- `y_q`, `all_hi`, `y_rise`, `hi_cnt`: 1-cycle latency from `a`/`b` sampled at an enabled edge.
- Reset value of every registered output is 0. `y` has no reset value and tracks its inputs during reset.
- Reset asserted mid-operation clears all registered state at the next edge, with no partial update. The first enabled edge after reset may raise `y_rise` for any bit with `a & b` = 1.
- Simultaneous `rst`=1 and `en`=1: reset wins.

## Test plan
- Combinational truth table, `WIDTH`=1, all 4 input combinations: `y` = 0, 0, 0, 1 for (0,0), (0,1), (1,0), (1,1), with no clock running.
- Chain of two instances, `a`=`b`=`c`=1 driven at t=0: final output = 1 at t=1. Dropping any one input to 0 gives final output = 0 in the same time step.
- `WIDTH`=4, `rst` for 2 cycles, then `a`=4'b1011, `b`=4'b1110, `en`=1: `y`=4'b1010 immediately. One edge later `y_q`=4'b1010 and `y_rise`=4'b1010, and the next edge with stable inputs gives `y_rise`=0.
- `en`=0 while the inputs change to `a`=`b`=4'hF: `y`=4'hF, while `y_q` holds 4'b1010, `y_rise`=0 and `all_hi`=0.
- `CNT_W`=3, `a`=`b`=all-ones, `en`=1 for 10 cycles: `hi_cnt` steps 1…7 and stays at 7. Asserting `rst` with `en`=1 gives `hi_cnt`=0, `y_q`=0 and `all_hi`=0 at the next edge.
